// File: rtl/prbs_point_gen_if.sv
// Point stream between prbs_point_gen (master) and its consumer (slave).
interface prbs_point_gen_if #(
  parameter int COORD_W = 12
);
  logic               out_valid;
  logic               out_ready;
  logic [COORD_W-1:0] x_out;
  logic [COORD_W-1:0] y_out;
  logic               last;

  modport master (output out_valid, x_out, y_out, last, input out_ready);
  modport slave  (input out_valid, x_out, y_out, last, output out_ready);
endinterface

// File: rtl/prbs_point_gen.sv
// Bounded stream of pseudo-random (x, y) pairs from two 32-bit Galois LFSRs.
// Define PRBS_LEAP_EN to advance each LFSR COORD_W steps per sample.
module prbs_point_gen #(
  parameter int          COORD_W  = 12,
  parameter logic [31:0] SEED     = 32'h0000_0001,
  parameter logic [31:0] Y_XOR    = 32'h5A5A_5A5A,
  parameter logic [31:0] TAP_MASK = 32'h8020_0003
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [31:0]            num_samples,
  input  logic                   seed_load,
  input  logic [31:0]            seed,
  prbs_point_gen_if.master       pt,
  output logic                   busy,
  output logic                   done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [31:0] seed_fix(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? TAP_MASK : 32'd0);
  endfunction

  function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
    logic [31:0] r;
    r = s;
`ifdef PRBS_LEAP_EN
    for (int i = 0; i < COORD_W; i++) r = lfsr_step(r);
`else
    r = lfsr_step(r);
`endif
    return r;
  endfunction

  localparam logic [31:0] RST_X = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0] RST_Y = ((SEED ^ Y_XOR) == 32'd0) ? 32'd1 : (SEED ^ Y_XOR);

  state_t             state_q, state_d;
  logic [31:0]        lfsr_x_q, lfsr_x_d, lfsr_y_q, lfsr_y_d;
  logic [31:0]        n_q, n_d, cnt_q, cnt_d;
  logic               valid_q, valid_d, last_q, last_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [31:0]        src_x, src_y, step_x, step_y;

  always_comb begin
    state_d  = state_q;
    lfsr_x_d = lfsr_x_q;
    lfsr_y_d = lfsr_y_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    last_d   = last_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    // A seed load in the same cycle as start feeds the first step directly.
    src_x    = lfsr_x_q;
    src_y    = lfsr_y_q;
    if (state_q == IDLE && seed_load) begin
      src_x = seed_fix(seed);
      src_y = seed_fix(seed ^ Y_XOR);
    end
    step_x = lfsr_adv(src_x);
    step_y = lfsr_adv(src_y);

    case (state_q)
      IDLE: begin
        lfsr_x_d = src_x;
        lfsr_y_d = src_y;
        if (start) begin
          if (num_samples != 32'd0) begin
            n_d      = num_samples;
            cnt_d    = 32'd0;
            lfsr_x_d = step_x;
            lfsr_y_d = step_y;
            x_d      = step_x[COORD_W-1:0];
            y_d      = step_y[COORD_W-1:0];
            valid_d  = 1'b1;
            busy_d   = 1'b1;
            last_d   = (num_samples == 32'd1);
            state_d  = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (valid_q && pt.out_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            lfsr_x_d = step_x;
            lfsr_y_d = step_y;
            x_d      = step_x[COORD_W-1:0];
            y_d      = step_y[COORD_W-1:0];
            cnt_d    = cnt_q + 32'd1;
            last_d   = (cnt_q + 32'd1 == n_q - 32'd1);
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lfsr_x_q <= RST_X;
      lfsr_y_q <= RST_Y;
      n_q      <= 32'd0;
      cnt_q    <= 32'd0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_x_q <= lfsr_x_d;
      lfsr_y_q <= lfsr_y_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  assign pt.out_valid = valid_q;
  assign pt.last      = last_q;
  assign pt.x_out     = x_q;
  assign pt.y_out     = y_q;
  assign busy         = busy_q;
  assign done         = done_q;
endmodule
